sap1_datapath: RTL
==================

# sap1_datapath

SAP-1 datapath: the responder to the SAP-1 controller's 12-bit control word. Holds the program counter, MAR, 16x8 RAM, instruction register, A/B registers, add/subtract ALU, output register and shared 8-bit bus. Executes one control word per clock edge and returns the current opcode for sequencing. Also provides a program-load port for initialising RAM.

## Interface
Parameters:
- DW, 8, data/bus width
- AW, 4, address width (RAM depth 2^AW)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-low reset
- CTRL  in  12  control word {CE,CO,MI,RO,II,IO,AI,AO,SU,EO,BI,OI}; CE = bit 11, OI = bit 0
- PROG_WE  in  1  RAM write strobe from loader
- PROG_ADDR  in  AW  loader address
- PROG_DATA  in  DW  loader data
- OPC  out  4  IR[7:4]
- BUS  out  DW  current bus value (combinational)
- OUT_VAL  out  DW  output register
- OUT_VALID  out  1  one-cycle pulse after OUT_VAL load
- CF, ZF  out  1  carry/zero flags
- BUS_ERR  out  1  sticky multiple-driver error

## Operation
- Bus drivers: CO -> {0, PC}; RO -> RAM[MAR]; IO -> {0, IR[3:0]}; AO -> A; EO -> ALU result. None asserted -> 8'h00.
- More than one driver asserted: BUS = 8'h00 that cycle; BUS_ERR set on next edge, stays set until reset. Loads still occur, taking 8'h00.
- Loads on rising edge from BUS: MI -> MAR <= BUS[3:0]; II -> IR; AI -> A; BI -> B; OI -> OUT_VAL, OUT_VALID high next cycle only.
- CE: PC <= PC+1, wraps 15 -> 0. CE with CO: bus carries the pre-increment PC.
- ALU: SU=0 -> A+B, SU=1 -> A+~B+1; 8-bit result wraps. CF = carry-out (for subtract, 1 = no borrow). ZF = (result == 0).
- Flags update only on edges where EO && AI; otherwise hold.
- Simultaneous AI and AO/EO: A loads the old-A-derived value (register semantics, no combinational loop).
- RAM is not cleared by reset. PROG_WE writes RAM[PROG_ADDR] on the edge, independent of RST and CTRL.
- PROG_WE and RO on the same address in one cycle: bus carries the old data; new data is visible next cycle.

## Timing
- Reset (RST=0 at edge): PC, MAR, IR, A, B, OUT_VAL = 0; CF, ZF, OUT_VALID, BUS_ERR = 0; OPC = 0.
- Reset wins over every CTRL bit in the same cycle. Reset mid-instruction discards partial state.
- Latency: register loads are visible one cycle after the edge. OPC follows IR with zero additional delay.
- BUS and ALU result are combinational from CTRL and registers within the cycle.
- CTRL must be stable before the rising edge. The controller changes CTRL on the falling edge.

## Structure
- Shared package sap1_pkg: control-bit index constants (CE_B=11 ... OI_B=0), DW/AW defaults, opcode constants (LDA=0, ADD=1, SUB=2, OUT=14, HLT=15).
- One sub-module sap1_alu: combinational add/sub producing result, carry and zero. Everything else stays in sap1_datapath.

## Test plan
- Reset, then CTRL=0 for 3 cycles -> all outputs 0, BUS=0x00, BUS_ERR=0.
- Load RAM[0]=0x1E via PROG port; CO|MI, then CE, then RO|II -> MAR=0, PC=1, IR=0x1E, OPC=1.
- RAM[14]=0x05, RAM[15]=0x03. Load A=0x05 and B=0x03 via IO|MI / RO|AI / RO|BI. EO|AI -> A=0x08, CF=0, ZF=0. Then SU|EO|AI -> A=0x05, CF=1.
- A=0x03, B=0x03, SU|EO|AI -> A=0x00, ZF=1, CF=1. Then OI|AO -> OUT_VAL=0x00, OUT_VALID high exactly one cycle.
- Assert CE for 17 cycles from reset -> PC=1 (wrapped once). Assert CO|AO -> BUS=0x00, BUS_ERR=1, stays 1 until RST low.
- Set A=0x55, then RST low together with AI|EO -> A=0, flags 0. RAM contents are unchanged afterwards.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 datapath: control-word bit positions,
// default widths, opcodes and a multi-driver detect helper.
package sap1_pkg;
    localparam int DW_DEF = 8;
    localparam int AW_DEF = 4;

    localparam int CE_B = 11;
    localparam int CO_B = 10;
    localparam int MI_B = 9;
    localparam int RO_B = 8;
    localparam int II_B = 7;
    localparam int IO_B = 6;
    localparam int AI_B = 5;
    localparam int AO_B = 4;
    localparam int SU_B = 3;
    localparam int EO_B = 2;
    localparam int BI_B = 1;
    localparam int OI_B = 0;

    localparam logic [3:0] LDA = 4'd0;
    localparam logic [3:0] ADD = 4'd1;
    localparam logic [3:0] SUB = 4'd2;
    localparam logic [3:0] OUT = 4'd14;
    localparam logic [3:0] HLT = 4'd15;

    // True when two or more bus drivers are enabled together.
    function automatic logic multi_hot(input logic [4:0] v);
        return (v & (v - 5'd1)) != 5'd0;
    endfunction
endpackage

// File: rtl/sap1_datapath_if.sv
// Controller/loader side of the SAP-1 datapath: control word, program port
// and the status returned for sequencing.
interface sap1_datapath_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic [11:0]   CTRL;
    logic          PROG_WE;
    logic [AW-1:0] PROG_ADDR;
    logic [DW-1:0] PROG_DATA;
    logic [3:0]    OPC;
    logic [DW-1:0] BUS;
    logic [DW-1:0] OUT_VAL;
    logic          OUT_VALID;
    logic          CF;
    logic          ZF;
    logic          BUS_ERR;

    modport master (
        output CTRL, PROG_WE, PROG_ADDR, PROG_DATA,
        input  OPC, BUS, OUT_VAL, OUT_VALID, CF, ZF, BUS_ERR
    );
    modport slave (
        input  CTRL, PROG_WE, PROG_ADDR, PROG_DATA,
        output OPC, BUS, OUT_VAL, OUT_VALID, CF, ZF, BUS_ERR
    );
endinterface

// File: rtl/sap1_alu.sv
// Combinational add/subtract; subtract is A + ~B + 1 so carry=1 means no borrow.
module sap1_alu #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_su,
    output logic [DW-1:0] o_res,
    output logic          o_carry,
    output logic          o_zero
);
    logic [DW:0]   w_sum;
    logic [DW-1:0] w_b;

    assign w_b     = i_su ? ~i_b : i_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_b} + {{DW{1'b0}}, i_su};
    assign o_res   = w_sum[DW-1:0];
    assign o_carry = w_sum[DW];
    assign o_zero  = (w_sum[DW-1:0] == '0);
endmodule

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: executes one 12-bit control word per rising edge over a
// shared bus and reports the current opcode back to the controller.
module sap1_datapath
    import sap1_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input logic            CLK,
    input logic            RST,
    sap1_datapath_if.slave dp
);
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_mar;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_out;
    logic          r_out_valid;
    logic          r_cf;
    logic          r_zf;
    logic          r_bus_err;
    logic [DW-1:0] r_ram [2**AW];

    logic [11:0]   w_ctrl;
    logic [4:0]    w_drv;
    logic          w_multi;
    logic [DW-1:0] w_bus;
    logic [DW-1:0] w_alu;
    logic          w_carry;
    logic          w_zero;

    assign w_ctrl  = dp.CTRL;
    assign w_drv   = {w_ctrl[CO_B], w_ctrl[RO_B], w_ctrl[IO_B], w_ctrl[AO_B], w_ctrl[EO_B]};
    assign w_multi = multi_hot(w_drv);

    sap1_alu #(.DW(DW)) u_alu (
        .i_a     (r_a),
        .i_b     (r_b),
        .i_su    (w_ctrl[SU_B]),
        .o_res   (w_alu),
        .o_carry (w_carry),
        .o_zero  (w_zero)
    );

    // Contention forces the bus to zero rather than picking a winner.
    always_comb begin
        w_bus = '0;
        if (!w_multi) begin
            if (w_ctrl[CO_B])      w_bus = DW'(r_pc);
            else if (w_ctrl[RO_B]) w_bus = r_ram[r_mar];
            else if (w_ctrl[IO_B]) w_bus = DW'(r_ir[3:0]);
            else if (w_ctrl[AO_B]) w_bus = r_a;
            else if (w_ctrl[EO_B]) w_bus = w_alu;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_pc        <= '0;
            r_mar       <= '0;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_cf        <= 1'b0;
            r_zf        <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            if (w_ctrl[CE_B]) r_pc  <= r_pc + 1'b1;
            if (w_ctrl[MI_B]) r_mar <= w_bus[AW-1:0];
            if (w_ctrl[II_B]) r_ir  <= w_bus;
            if (w_ctrl[AI_B]) r_a   <= w_bus;
            if (w_ctrl[BI_B]) r_b   <= w_bus;
            if (w_ctrl[OI_B]) r_out <= w_bus;
            r_out_valid <= w_ctrl[OI_B];
            if (w_ctrl[EO_B] && w_ctrl[AI_B]) begin
                r_cf <= w_carry;
                r_zf <= w_zero;
            end
            if (w_multi) r_bus_err <= 1'b1;
        end
    end

    // Program memory survives reset; the loader port is always live.
    always_ff @(posedge CLK) begin
        if (dp.PROG_WE) r_ram[dp.PROG_ADDR] <= dp.PROG_DATA;
    end

    assign dp.OPC       = r_ir[DW-1 -: 4];
    assign dp.BUS       = w_bus;
    assign dp.OUT_VAL   = r_out;
    assign dp.OUT_VALID = r_out_valid;
    assign dp.CF        = r_cf;
    assign dp.ZF        = r_zf;
    assign dp.BUS_ERR   = r_bus_err;
endmodule
